// File: rtl/shift_reg_univ_if.sv
// Control/data bundle for the universal shift register.
// The master drives mode and data requests; the slave returns register state and status.
interface shift_reg_univ_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) ();
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic             start;
    logic [CNT_W-1:0] nshift;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    modport master (
        output mode, d, sin, start, nshift,
        input  q, qbar, sout_l, sout_r, busy, done
    );

    modport slave (
        input  mode, d, sin, start, nshift,
        output q, qbar, sout_l, sout_r, busy, done
    );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal register: per-cycle hold/shift/rotate/load/clear/set plus a counted burst
// engine that repeats one shift/rotate step nshift times and flags busy/done.
module shift_reg_univ #(
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    shift_reg_univ_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_bmode;
    logic             r_done;
    logic             w_burst_mode;

    // Next register value for a given mode; burst modes never reach load/clear/set.
    function automatic logic [WIDTH-1:0] f_next(input logic [2:0]       m,
                                                input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] d,
                                                input logic             s);
        logic [WIDTH-1:0] r;
        case (m)
            3'b000:  r = q;
            3'b001:  r = {q[WIDTH-2:0], s};
            3'b010:  r = {s, q[WIDTH-1:1]};
            3'b011:  r = {q[WIDTH-2:0], q[WIDTH-1]};
            3'b100:  r = {q[0], q[WIDTH-1:1]};
            3'b101:  r = d;
            3'b110:  r = '0;
            default: r = '1;
        endcase
        return r;
    endfunction

    // Only shift and rotate modes can launch a burst.
    assign w_burst_mode = (bus.mode >= 3'b001) && (bus.mode <= 3'b100);

    // Burst FSM and register state; done is registered alongside the DONE state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_q     <= RESET_VAL;
            r_count <= '0;
            r_bmode <= 3'b000;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.start && w_burst_mode) begin
                        r_bmode <= bus.mode;
                        if (bus.nshift == '0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_q <= f_next(bus.mode, r_q, bus.d, bus.sin);
                            if (bus.nshift == CNT_W'(1)) begin
                                r_state <= StDone;
                                r_done  <= 1'b1;
                            end else begin
                                r_count <= bus.nshift - CNT_W'(1);
                                r_state <= StRun;
                            end
                        end
                    end else begin
                        r_q <= f_next(bus.mode, r_q, bus.d, bus.sin);
                    end
                end
                StRun: begin
                    r_q     <= f_next(r_bmode, r_q, bus.d, bus.sin);
                    r_count <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.q      = r_q;
    assign bus.qbar   = ~r_q;
    assign bus.sout_l = r_q[WIDTH-1];
    assign bus.sout_r = r_q[0];
    assign bus.busy   = (r_state != StIdle);
    assign bus.done   = r_done;

endmodule
